// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: PAUSED/RUN/ADJ sequencing of a minutes:seconds count with registered display.
// Optional lap hold is built only when STOPWATCH_CTRL_LAP_EN is defined.
//
// state  | meaning
// PAUSED | count held, waiting for btn_pause to resume
// RUN    | count advances on tick_1hz
// ADJ    | selected field increments on tick_fast, no carry
module stopwatch_ctrl #(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_fast,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       btn_lap,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [6:0] disp_min,
    output logic [5:0] disp_sec,
    output logic       running,
    output logic       adj_blink,
    output logic       lap_active
);

    typedef enum logic [1:0] {PAUSED, RUN, ADJ} state_t;

    localparam logic [5:0] SEC_LAST = 6'(SEC_MAX);
    localparam logic [6:0] MIN_LAST = 7'(MIN_MAX);

    state_t     state_q, state_d;
    logic [5:0] sec_q, sec_d;
    logic [6:0] min_q, min_d;
    logic [5:0] dsec_q, dsec_d;
    logic [6:0] dmin_q, dmin_d;
    logic       blink_q, blink_d;
    logic       lap_q, lap_d;
    logic       armed_q, armed_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAUSED;
            sec_q   <= '0;
            min_q   <= '0;
            dsec_q  <= '0;
            dmin_q  <= '0;
            blink_q <= 1'b0;
            lap_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            dsec_q  <= dsec_d;
            dmin_q  <= dmin_d;
            blink_q <= blink_d;
            lap_q   <= lap_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        blink_d = blink_q;
        lap_d   = lap_q;
        armed_d = 1'b1;

        // The first edge out of reset only arms the block; all inputs are ignored on it.
        if (armed_q) begin
            case (state_q)
                PAUSED:  if (sw_adj) state_d = ADJ; else if (btn_pause) state_d = RUN;
                RUN:     if (sw_adj) state_d = ADJ; else if (btn_pause) state_d = PAUSED;
                ADJ:     if (!sw_adj) state_d = PAUSED;
                default: state_d = PAUSED;
            endcase

            if (state_q == RUN && tick_1hz) begin
                if (sec_q == SEC_LAST) begin
                    sec_d = '0;
                    min_d = (min_q == MIN_LAST) ? 7'd0 : min_q + 7'd1;
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end

            if (state_q == ADJ && tick_fast) begin
                if (sw_sel) min_d = (min_q == MIN_LAST) ? 7'd0 : min_q + 7'd1;
                else        sec_d = (sec_q == SEC_LAST) ? 6'd0 : sec_q + 6'd1;
            end

            if (btn_reset) begin
                sec_d = '0;
                min_d = '0;
            end

            // Blink restarts at 0 on ADJ entry and only toggles while staying in ADJ.
            if (state_q == ADJ && state_d == ADJ) blink_d = blink_q ^ tick_fast;
            else                                  blink_d = 1'b0;

`ifdef STOPWATCH_CTRL_LAP_EN
            if (btn_reset || state_d != RUN)       lap_d = 1'b0;
            else if (state_q == RUN && btn_lap)    lap_d = ~lap_q;
`else
            lap_d = 1'b0;
`endif
        end

        if (lap_d) begin
            dsec_d = dsec_q;
            dmin_d = dmin_q;
        end else begin
            dsec_d = sec_d;
            dmin_d = min_d;
        end
    end

`ifndef STOPWATCH_CTRL_LAP_EN
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
`endif

    assign disp_min   = dmin_q;
    assign disp_sec   = dsec_q;
    assign running    = (state_q == RUN);
    assign adj_blink  = blink_q;
    assign lap_active = lap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with hand-computed expectations; lap checks adapt to STOPWATCH_CTRL_LAP_EN.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz, tick_fast, btn_pause, btn_reset, btn_lap, sw_adj, sw_sel;
    logic [6:0] disp_min;
    logic [5:0] disp_sec;
    logic       running, adj_blink, lap_active;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef STOPWATCH_CTRL_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .tick_fast  (tick_fast),
        .btn_pause  (btn_pause),
        .btn_reset  (btn_reset),
        .btn_lap    (btn_lap),
        .sw_adj     (sw_adj),
        .sw_sel     (sw_sel),
        .disp_min   (disp_min),
        .disp_sec   (disp_sec),
        .running    (running),
        .adj_blink  (adj_blink),
        .lap_active (lap_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input int mm, input int ss);
        chk({tag, "_min"}, int'(disp_min), mm);
        chk({tag, "_sec"}, int'(disp_sec), ss);
    endtask

    // Inputs are changed 1 ns after a rising edge and outputs sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
        end
    endtask

    task automatic fast(input int n);
        for (int i = 0; i < n; i++) begin
            tick_fast = 1'b1;
            step();
            tick_fast = 1'b0;
        end
    endtask

    task automatic pause_pulse();
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
    endtask

    task automatic lap_pulse();
        btn_lap = 1'b1;
        step();
        btn_lap = 1'b0;
    endtask

    // Preset via ADJ: add dm to minutes and ds to seconds, return to PAUSED, then resume RUN.
    task automatic adjust_then_run(input int dm, input int ds);
        sw_adj = 1'b1;
        step();
        sw_sel = 1'b1;
        fast(dm);
        sw_sel = 1'b0;
        fast(ds);
        sw_adj = 1'b0;
        step();
        pause_pulse();
    endtask

    initial begin
        rst_n = 1'b0;
        {tick_1hz, tick_fast, btn_pause, btn_reset, btn_lap, sw_adj, sw_sel} = '0;
        #2;
        chk_disp("reset_disp", 0, 0);
        chk("reset_running", int'(running), 0);
        chk("reset_blink", int'(adj_blink), 0);
        chk("reset_lap", int'(lap_active), 0);

        // btn_pause held across the first edge after reset release must be ignored.
        @(negedge clk);
        rst_n     = 1'b1;
        btn_pause = 1'b1;
        step();
        btn_pause = 1'b0;
        chk("first_edge_ignored", int'(running), 0);

        pause_pulse();
        chk("pause_to_run", int'(running), 1);
        tick1(1);
        chk_disp("first_tick_latency", 0, 1);
        tick1(60);
        chk_disp("after_61_ticks", 1, 1);
        chk("run_after_61", int'(running), 1);

        pause_pulse();
        chk("run_to_pause", int'(running), 0);
        tick1(1);
        chk_disp("tick_ignored_paused", 1, 1);

        sw_adj = 1'b1;
        step();
        chk("blink_on_adj_entry", int'(adj_blink), 0);
        chk("running_in_adj", int'(running), 0);
        tick1(1);
        chk_disp("tick_ignored_adj", 1, 1);
        sw_sel = 1'b0;
        fast(1);
        chk("blink_first_toggle", int'(adj_blink), 1);
        chk_disp("adj_sec_inc", 1, 2);
        pause_pulse();
        chk("pause_ignored_adj", int'(adj_blink), 1);
        fast(57);
        chk_disp("adj_sec_59", 1, 59);
        chk("blink_after_58", int'(adj_blink), 0);
        fast(1);
        chk_disp("adj_sec_wrap_no_carry", 1, 0);
        chk("blink_after_59", int'(adj_blink), 1);

        sw_sel = 1'b1;
        fast(98);
        chk_disp("adj_min_99", 99, 0);
        fast(1);
        chk_disp("adj_min_wrap", 0, 0);
        fast(99);
        sw_sel = 1'b0;
        fast(59);
        chk_disp("preset_99_59", 99, 59);
        sw_adj = 1'b0;
        step();
        chk("blink_zero_after_adj", int'(adj_blink), 0);
        chk("adj_exit_paused", int'(running), 0);
        pause_pulse();
        chk("run_at_99_59", int'(running), 1);
        tick1(1);
        chk_disp("full_wrap", 0, 0);

        adjust_then_run(5, 30);
        chk_disp("preset_05_30", 5, 30);
        chk("run_at_05_30", int'(running), 1);
        tick_1hz  = 1'b1;
        btn_reset = 1'b1;
        step();
        tick_1hz  = 1'b0;
        btn_reset = 1'b0;
        chk_disp("reset_beats_tick", 0, 0);
        chk("running_after_clear", int'(running), 1);

        tick1(10);
        chk_disp("at_00_10", 0, 10);
        lap_pulse();
        chk("lap_on", int'(lap_active), LAP ? 1 : 0);
        tick1(5);
        chk_disp("lap_held", 0, LAP ? 10 : 15);
        chk("lap_still_on", int'(lap_active), LAP ? 1 : 0);
        lap_pulse();
        chk("lap_off", int'(lap_active), 0);
        chk_disp("lap_released", 0, 15);

        lap_pulse();
        btn_reset = 1'b1;
        step();
        btn_reset = 1'b0;
        chk("lap_cleared_by_reset", int'(lap_active), 0);
        chk_disp("disp_after_lap_reset", 0, 0);

        adjust_then_run(12, 33);
        tick1(1);
        chk_disp("at_12_34", 12, 34);
        lap_pulse();
        chk("lap_before_async", int'(lap_active), LAP ? 1 : 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_disp("async_reset_disp", 0, 0);
        chk("async_reset_running", int'(running), 0);
        chk("async_reset_blink", int'(adj_blink), 0);
        chk("async_reset_lap", int'(lap_active), 0);
        step();
        chk_disp("held_in_reset", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter SEC_MAX, default 59, meaning the last seconds value before wrap.
REQ-002 SHALL have parameter MIN_MAX, default 99, meaning the last minutes value before wrap; legal range 1..127.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tick_1hz, input, 1 bit: single-cycle count-rate pulse from the clock-divider block.
REQ-006 SHALL have port tick_fast, input, 1 bit: single-cycle adjust/blink-rate pulse from the clock-divider block.
REQ-007 SHALL have port btn_pause, input, 1 bit: debounced single-cycle pause/resume pulse.
REQ-008 SHALL have port btn_reset, input, 1 bit: debounced single-cycle count-clear pulse.
REQ-009 SHALL have port btn_lap, input, 1 bit: debounced single-cycle lap-hold pulse.
REQ-010 SHALL have port sw_adj, input, 1 bit: level; 1 selects adjust mode.
REQ-011 SHALL have port sw_sel, input, 1 bit: level; adjust field select, 0 = seconds, 1 = minutes.
REQ-012 SHALL have port disp_min, output, 7 bits: displayed minutes, registered.
REQ-013 SHALL have port disp_sec, output, 6 bits: displayed seconds, registered.
REQ-014 SHALL have port running, output, 1 bit: 1 iff the state is RUN.
REQ-015 SHALL have port adj_blink, output, 1 bit: blink phase for the selected field in ADJ.
REQ-016 SHALL have port lap_active, output, 1 bit: 1 while the display is frozen by lap hold.

Function
REQ-017 SHALL implement exactly three states: PAUSED, RUN, ADJ.
REQ-018 SHALL move from PAUSED to RUN, and from RUN to PAUSED, on btn_pause while sw_adj=0.
REQ-019 SHALL enter ADJ from any state on the cycle after sw_adj is sampled 1, and SHALL go from ADJ to PAUSED on the cycle after sw_adj is sampled 0.
REQ-020 SHALL, in RUN only, advance the count by one second on tick_1hz: seconds SEC_MAX wraps to 0 and carries into minutes; MIN_MAX:SEC_MAX wraps to 00:00.
REQ-021 SHALL, in ADJ, increment the field selected by sw_sel on each tick_fast, with no carry between fields: seconds SEC_MAX wraps to 0, minutes MIN_MAX wraps to 0.
REQ-022 SHALL ignore tick_1hz in PAUSED and ADJ, and SHALL ignore btn_pause in ADJ.
REQ-023 SHALL present a count update on the outputs exactly one clock after the causing tick (one-cycle latency).
REQ-024 SHALL, on btn_reset, clear the count to 00:00 in any state without changing state; btn_reset has priority over a tick in the same cycle.
REQ-025 SHALL, when btn_pause and tick_1hz coincide in RUN, apply the tick and then enter PAUSED.
REQ-026 SHALL toggle adj_blink on each tick_fast while in ADJ; adj_blink SHALL be 0 outside ADJ and on the cycle ADJ is entered.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force: state PAUSED, count 00:00, disp 00:00, running=0, adj_blink=0, lap_active=0.
REQ-028 SHALL ignore all inputs on the first clock edge after rst_n deasserts.

Configuration
REQ-029 SHALL gate the lap-hold feature with macro STOPWATCH_CTRL_LAP_EN.
REQ-030 SHALL, with STOPWATCH_CTRL_LAP_EN defined, behave as follows:
- btn_lap in RUN toggles lap_active.
- While lap_active=1, disp_* hold the value captured at the press while internal counting continues.
- btn_reset, or leaving RUN, clears lap_active.
- Display resumes the live count the cycle after release.
REQ-031 SHALL, without STOPWATCH_CTRL_LAP_EN, keep port btn_lap but ignore it, tie lap_active to 0, and make disp_* always equal the live count.

Verification
REQ-032 SHALL cover: reset, btn_pause, 61 tick_1hz -> running=1, disp 01:01.
REQ-033 SHALL cover: count preset to 99:59 in RUN, one tick_1hz -> 00:00 the next cycle.
REQ-034 SHALL cover: sw_adj=1, sw_sel=0, seconds at 59, one tick_fast -> 00 seconds, minutes unchanged; adj_blink toggles each tick_fast.
REQ-035 SHALL cover: btn_reset coinciding with tick_1hz at 05:30 in RUN -> 00:00, running stays 1.
REQ-036 SHALL cover: with LAP_EN, btn_lap at 00:10, then 5 ticks -> disp 00:10 and lap_active=1; second btn_lap -> disp 00:15.
REQ-037 SHALL cover: rst_n pulled low mid-RUN at 12:34 -> all outputs at reset values immediately, without waiting for a clock edge.
